// File: rtl/click_decoder.sv
// click_decoder: groups debounced press pulses into click-count events.
// Optional CLICK_DECODER_OVERWRITE_EN: newest event replaces a pending one.
module click_decoder #(
  parameter int WINDOW_COUNTER_WIDTH = 26,
  parameter int CLICK_WINDOW = 37_500_000,
  parameter int MAX_CLICKS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       press,
  output logic       event_valid,
  output logic [2:0] event_count,
  input  logic       event_ready,
  output logic       overflow
);

  localparam int W = WINDOW_COUNTER_WIDTH;
  localparam logic [W-1:0] T_LAST = W'(CLICK_WINDOW - 1);
  localparam logic [2:0] MAX_C = 3'(MAX_CLICKS);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t       state, state_n;
  logic [2:0]   cnt, cnt_n;
  logic [W-1:0] timer, timer_n;
  logic         valid_n;
  logic [2:0]   count_n;
  logic         ovf_n;
  logic         done;
  logic [2:0]   done_cnt;
  logic         free;
  logic [2:0]   cnt_inc;

  assign cnt_inc = cnt + 3'd1;
  assign free = !event_valid || event_ready;

  // State, group tracking and output register update
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      event_valid <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      event_valid <= valid_n;
      event_count <= count_n;
      overflow    <= ovf_n;
    end
  end

  // Group collection, completion and handoff to the output register
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    timer_n  = timer;
    done     = 1'b0;
    done_cnt = '0;
    valid_n  = event_valid;
    count_n  = event_count;
    ovf_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (press) begin
          cnt_n   = 3'd1;
          timer_n = '0;
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (press) begin
          cnt_n   = cnt_inc;
          timer_n = '0;
          if (cnt_inc == MAX_C) begin
            done     = 1'b1;
            done_cnt = cnt_inc;
          end
        end else if (timer == T_LAST) begin
          done     = 1'b1;
          done_cnt = cnt;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (done) begin
      state_n = IDLE;
      cnt_n   = '0;
      timer_n = '0;
    end

    if (done && free) begin
      valid_n = 1'b1;
      count_n = done_cnt;
    end else if (done) begin
      ovf_n = 1'b1;
`ifdef CLICK_DECODER_OVERWRITE_EN
      count_n = done_cnt;
`else
      count_n = event_count;
`endif
    end else if (event_valid && event_ready) begin
      valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_click_decoder.sv
// tb_click_decoder: directed and random presses checked every cycle
// against a gap-based reference model of click grouping.
module tb_click_decoder;

  localparam int CW = 10;
  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       press = 1'b0;
  logic       event_valid;
  logic [2:0] event_count;
  logic       event_ready = 1'b1;
  logic       overflow;

  click_decoder #(
    .WINDOW_COUNTER_WIDTH(4),
    .CLICK_WINDOW(CW),
    .MAX_CLICKS(MAXC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .press(press),
    .event_valid(event_valid),
    .event_count(event_count),
    .event_ready(event_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails = 0;

  // reference model: group membership decided by gap since last press
  int cyc = 0;
  int last = 0;
  bit in_grp = 0;
  int gcnt = 0;
  bit mv = 0;
  int mc = 0;
  bit mo = 0;

  task automatic model_edge(input bit p, input bit r, input bit rn);
    bit done;
    int dc;
    done = 0;
    dc = 0;
    if (!rn) begin
      in_grp = 0; gcnt = 0; mv = 0; mc = 0; mo = 0;
      return;
    end
    if (!in_grp) begin
      if (p) begin
        in_grp = 1; gcnt = 1; last = cyc;
      end
    end else if (p) begin
      gcnt++;
      last = cyc;
      if (gcnt == MAXC) begin done = 1; dc = gcnt; end
    end else if (cyc - last == CW) begin
      done = 1; dc = gcnt;
    end
    if (done) begin in_grp = 0; gcnt = 0; end
    mo = 0;
    if (done && (!mv || r)) begin
      mv = 1; mc = dc;
    end else if (done) begin
      mo = 1;
`ifdef CLICK_DECODER_OVERWRITE_EN
      mc = dc;
`endif
    end else if (mv && r) begin
      mv = 0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input bit p, input bit r, input bit rn);
    press = p;
    event_ready = r;
    reset_n = rn;
    @(posedge clk);
    model_edge(p, r, rn);
    cyc++;
    #1;
    chk("event_valid", int'(event_valid), int'(mv));
    chk("overflow", int'(overflow), int'(mo));
    if (mv) chk("event_count", int'(event_count), mc);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(0, r, 1);
  endtask

  initial begin
    // reset state
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    chk("reset_count", int'(event_count), 0);
    idle(3, 1);

    // single click times out after the window
    cycle(1, 1, 1);
    idle(14, 1);

    // double click with gap of 5
    cycle(1, 1, 1);
    idle(4, 1);
    cycle(1, 1, 1);
    idle(14, 1);

    // triple click completes immediately, next press starts new group
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    cycle(1, 1, 1);
    cycle(0, 1, 1);
    cycle(1, 1, 1);
    chk("triple_now", int'(event_count), 3);
    cycle(1, 1, 1);
    idle(14, 1);

    // press exactly at the last window cycle joins the group
    cycle(1, 1, 1);
    idle(9, 1);
    cycle(1, 1, 1);
    idle(14, 1);

    // consumer stalled: second event collides with pending one
    cycle(1, 0, 1);
    idle(11, 0);
    cycle(1, 0, 1);
    idle(4, 0);
    cycle(1, 0, 1);
    idle(12, 0);
    idle(3, 1);

    // reset mid-group loses the group
    cycle(1, 1, 1);
    idle(2, 1);
    cycle(0, 1, 0);
    chk("midreset_valid", int'(event_valid), 0);
    chk("midreset_count", int'(event_count), 0);
    idle(14, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit p, r, rn;
      p = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 199) != 0);
      cycle(p, r, rn);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
